fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 83 ++++++++
 tb/tb_fetch_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: PC, instruction-memory, redirect and decode-handshake bundle of the fetch unit.
interface fetch_unit_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] next_PC;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic [WIDTH-1:0] imem_rdata;
    logic             redirect;
    logic [WIDTH-1:0] redirect_target;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] instr_pc;
    logic             fetch_fault;
    modport master (
        input  pc, imem_rdata, redirect, redirect_target, instr_ready,
        output next_PC, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault
    );
    modport slave (
        output pc, imem_rdata, redirect, redirect_target, instr_ready,
        input  next_PC, imem_req, imem_addr, instr_valid, instr, instr_pc, fetch_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC sequencing, instruction-memory requests and a small decode queue.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects raise a sticky fault and halt instead of being realigned.
module fetch_unit #(
    parameter int WIDTH  = 32,
    parameter int QDEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master fu
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;
    state_e           state_q, state_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic             infl_q, infl_d, fault_q, fault_d;
    logic [WIDTH-1:0] infl_pc_q;
    logic [WIDTH-1:0] hold_instr_q, hold_pc_q;
    logic [WIDTH-1:0] data_q [QDEPTH];
    logic [WIDTH-1:0] addr_q [QDEPTH];
    logic [WIDTH-1:0] target;
    logic             run, misaligned, flush, enq, deq, valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = fu.redirect_target[1:0] != 2'b00;
    assign target     = fu.redirect_target;
`else
    logic unused_target_lsbs;
    assign unused_target_lsbs = ^fu.redirect_target[1:0];
    assign misaligned = 1'b0;
    assign target     = {fu.redirect_target[WIDTH-1:2], 2'b00};
`endif
    assign run   = !rst && state_q == RUN;
    assign flush = run && fu.redirect;
    assign valid = !rst && cnt_q != '0;
    assign deq   = valid && fu.instr_ready;
    // a redirect kills the response arriving this cycle by never enqueuing it
    assign enq   = run && infl_q && !fu.redirect;
    assign fu.imem_req    = run && !fu.redirect && (int'(cnt_q) + int'(infl_q) < QDEPTH);
    assign fu.imem_addr   = fu.pc;
    assign fu.next_PC     = rst ? '0 : !run ? fu.pc :
                            fu.redirect ? (misaligned ? fu.pc : target) :
                            fu.imem_req ? fu.pc + WIDTH'(4) : fu.pc;
    assign fu.instr_valid = valid;
    assign fu.instr       = valid ? data_q[rd_q] : hold_instr_q;
    assign fu.instr_pc    = valid ? addr_q[rd_q] : hold_pc_q;
    assign fu.fetch_fault = fault_q && !rst;
    always_comb begin
        state_d = state_q == IDLE ? RUN : (flush && misaligned) ? HALT : state_q;
        cnt_d   = flush ? '0 : cnt_q + (AW+1)'(enq) - (AW+1)'(deq);
        rd_d    = flush ? '0 : rd_q + AW'(deq);
        wr_d    = flush ? '0 : wr_q + AW'(enq);
        fault_d = fault_q || (flush && misaligned);
        infl_d  = fu.imem_req;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            infl_q       <= 1'b0;
            fault_q      <= 1'b0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            infl_q       <= infl_d;
            fault_q      <= fault_d;
            hold_instr_q <= fu.instr;
            hold_pc_q    <= fu.instr_pc;
        end
    end
    always_ff @(posedge clk) begin
        if (enq) begin
            data_q[wr_q] <= fu.imem_rdata;
            addr_q[wr_q] <= infl_pc_q;
        end
        if (fu.imem_req) infl_pc_q <= fu.pc;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized stimulus checked against a queue-based fetch reference model.
module tb_fetch_unit;
    localparam int QDEPTH = 2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic FAULT_EXP = 1'b1;
`else
    localparam logic FAULT_EXP = 1'b0;
`endif
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] junk = '0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          req_seen = 0;
    int          m_state = 0;
    bit          m_fault = 1'b0;
    bit          m_infl = 1'b0;
    logic [31:0] m_infl_pc = '0;
    logic [31:0] m_last_instr = '0;
    logic [31:0] m_last_pc = '0;
    ent_t        m_q[$];

    fetch_unit_if #(.WIDTH(32)) bus ();
    fetch_unit #(.WIDTH(32), .QDEPTH(QDEPTH)) dut (.clk(clk), .rst(rst), .fu(bus));

    always #5 clk = ~clk;

    // PC register plus a memory returning word k at address 4k one cycle after a request
    always @(posedge clk) begin
        bus.pc    <= bus.next_PC;
        prev_req  <= bus.imem_req;
        prev_addr <= bus.imem_addr;
        junk      <= $urandom;
    end
    assign bus.imem_rdata = prev_req ? prev_addr >> 2 : junk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic cycle(input logic r, input logic rd, input logic [31:0] tg, input logic rdy);
        logic        run, mis, xreq, xvalid;
        logic [31:0] tgt, xnext, xinstr, xipc;
        @(posedge clk);
        #1;
        rst = r;
        bus.redirect = rd;
        bus.redirect_target = tg;
        bus.instr_ready = rdy;
        @(negedge clk);
        run = !rst && m_state == 1;
`ifdef FETCH_MISALIGN_TRAP_EN
        mis = bus.redirect_target[1:0] != 2'b00;
        tgt = bus.redirect_target;
`else
        mis = 1'b0;
        tgt = bus.redirect_target & ~32'h3;
`endif
        xreq   = run && !bus.redirect && (m_q.size() + int'(m_infl) < QDEPTH);
        xnext  = rst ? 32'h0 : !run ? bus.pc : bus.redirect ? (mis ? bus.pc : tgt) :
                 xreq ? bus.pc + 32'd4 : bus.pc;
        xvalid = !rst && m_q.size() != 0;
        xinstr = xvalid ? m_q[0].instr : m_last_instr;
        xipc   = xvalid ? m_q[0].pc : m_last_pc;
        req_seen += int'(bus.imem_req);
        check("imem_req", bus.imem_req, xreq);
        check("next_PC", bus.next_PC, xnext);
        check("imem_addr", bus.imem_addr, bus.pc);
        check("instr_valid", bus.instr_valid, xvalid);
        check("fetch_fault", bus.fetch_fault, !rst && m_fault);
        if (!rst) begin
            check("instr", bus.instr, xinstr);
            check("instr_pc", bus.instr_pc, xipc);
        end
        m_last_instr = rst ? 32'h0 : xinstr;
        m_last_pc    = rst ? 32'h0 : xipc;
        if (rst) begin
            m_q.delete();
            m_infl  = 1'b0;
            m_state = 0;
            m_fault = 1'b0;
        end else begin
            if (xvalid && bus.instr_ready) void'(m_q.pop_front());
            if (run && bus.redirect) begin
                m_q.delete();
                if (mis) begin
                    m_fault = 1'b1;
                    m_state = 2;
                end
            end else if (run && m_infl) begin
                m_q.push_back('{m_infl_pc >> 2, m_infl_pc});
            end
            if (m_state == 0) m_state = 1;
            m_infl    = xreq;
            m_infl_pc = bus.pc;
        end
    endtask

    initial begin
        bus.redirect = 1'b0;
        bus.redirect_target = '0;
        bus.instr_ready = 1'b0;
        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (20) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b1);
        req_seen = 0;
        repeat (8) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_reqs", req_seen, QDEPTH);
        check("stall_pc", bus.pc, 32'h8);
        repeat (3) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h100, 1'b1);
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        repeat (6) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'h102, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("misalign_fault", bus.fetch_fault, FAULT_EXP);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        repeat (2) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
        check("rst_valid", bus.instr_valid, 1'b0);
        repeat (10) cycle(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] tg;
            int          sel;
            tg  = $urandom;
            sel = $urandom_range(0, 3);
            tg  = sel == 0 ? (32'hFFFF_FFF0 | (tg & 32'hC)) : sel == 3 ? tg : tg & ~32'h3;
            cycle($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8, tg,
                  $urandom_range(0, 99) < 70);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
